// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: DEPTH entries of {pc, instr}.
// Push, pop and flush may coincide; flush wins and empties the buffer.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is not reset; the head is masked with count, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // When full with push+pop, the write lands on the slot being popped; head is read before the edge.
  assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: computes pc_next for the PC register, runs the imem
// req/ack handshake and buffers fetched words towards decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int INSTR_BYTES = fetch_pkg::INSTR_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_now,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  localparam int          CW  = $clog2(DEPTH) + 1;
  localparam logic [31:0] INC = 32'(INSTR_BYTES);

  state_t       state, state_nx;
  logic [31:0]  addr_nx;
  logic [CW-1:0] count;
  fetch_entry_t head;
  logic         pop, ack_acc, push, space, room_after;

  assign pop        = instr_valid && !stall;
  assign ack_acc    = (state == S_REQ) && imem_ack;
  assign push       = ack_acc && !redirect;
  // Occupancy after this cycle's pop, before any push; and including the push.
  assign space      = (int'(count) - int'(pop)) < DEPTH;
  assign room_after = (int'(count) + 1 - int'(pop)) < DEPTH;

  always_comb begin
    if (redirect)     pc_next = {redirect_pc[31:2], 2'b00};
    else if (ack_acc) pc_next = pc_now + INC;
    else              pc_next = pc_now;
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nx = state;
    addr_nx  = imem_addr;
    unique case (state)
      S_IDLE: begin
        if (!redirect && space) begin
          addr_nx  = pc_now;
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          if (redirect)        state_nx = S_IDLE;
          else if (room_after) addr_nx  = pc_now + INC;
          else                 state_nx = S_IDLE;
        end else if (redirect) begin
          state_nx = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      imem_addr    <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nx;
      imem_addr    <= addr_nx;
      misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
    end
  end

  // Request follows state directly so an asserted reset drops it at once.
  assign imem_req = (state != S_IDLE);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ('{pc: imem_addr, instr: imem_rdata}),
    .head  (head),
    .count (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: table-driven start-up sequence, directed
// corner cases and a scoreboard comparing every word handed to decode.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk, rst;
  logic [31:0] pc_now, pc_next, imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic        imem_req, imem_ack, redirect, stall, instr_valid, misalign_err;

  int checks = 0;
  int errors = 0;
  bit auto_ack = 0;
  bit drop_flag = 0;
  fetch_entry_t sb_q[$];

  fetch_ctrl #(.DEPTH(2), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst(rst), .pc_now(pc_now), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .misalign_err(misalign_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: pop/compare on every decode handshake, flush on redirect,
  // push on every acknowledged request that has not been abandoned.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      drop_flag = 0;
    end else begin
      if (instr_valid && !stall) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_pop_pc", instr_pc, 32'hFFFF_FFFF);
        end else begin
          fetch_entry_t e;
          e = sb_q.pop_front();
          check("sb_instr_pc", instr_pc, e.pc);
          check("sb_instr", instr, e.instr);
        end
      end
      if (redirect) sb_q.delete();
      else if (imem_req && imem_ack && !drop_flag) sb_q.push_back('{pc: pc_now, instr: mem_word(pc_now)});
      if (imem_req && imem_ack)            drop_flag = 0;
      else if (imem_req && redirect)       drop_flag = 1;
    end
  end

  task automatic prep();
    #1;
    if (auto_ack) imem_ack = imem_req;
    #1;
  endtask

  task automatic tick();
    logic [31:0] p;
    p = pc_next;
    @(posedge clk);
    #1;
    pc_now   = rst ? 32'h0 : p;
    redirect = 0;
    if (auto_ack) imem_ack = 0;
  endtask

  task automatic do_reset(input bit check_outputs);
    rst = 1; pc_now = 0; imem_ack = 0; redirect = 0; redirect_pc = 0;
    stall = 0; auto_ack = 0;
    tick();
    if (check_outputs) begin
      #1;
      check("rst_imem_req", 32'(imem_req), 0);
      check("rst_imem_addr", imem_addr, 0);
      check("rst_instr_valid", 32'(instr_valid), 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
      check("rst_misalign", 32'(misalign_err), 0);
    end
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc_nx;
    logic        valid;
    logic [31:0] ipc;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{req: 0, addr: 32'h0, pc_nx: 32'h0,  valid: 0, ipc: 32'h0};
    vecs[1] = '{req: 1, addr: 32'h0, pc_nx: 32'h4,  valid: 0, ipc: 32'h0};
    vecs[2] = '{req: 1, addr: 32'h4, pc_nx: 32'h8,  valid: 1, ipc: 32'h0};
    vecs[3] = '{req: 1, addr: 32'h8, pc_nx: 32'hC,  valid: 1, ipc: 32'h4};
    vecs[4] = '{req: 1, addr: 32'hC, pc_nx: 32'h10, valid: 1, ipc: 32'h8};

    // Streaming fetch from reset, ack in every requested cycle.
    do_reset(1);
    auto_ack = 1;
    for (int i = 0; i < 5; i++) begin
      prep();
      check($sformatf("t%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      check($sformatf("t%0d_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("t%0d_pc_next", i), pc_next, vecs[i].pc_nx);
      check($sformatf("t%0d_valid", i), 32'(instr_valid), 32'(vecs[i].valid));
      check($sformatf("t%0d_instr_pc", i), instr_pc, vecs[i].ipc);
      check($sformatf("t%0d_instr", i), instr, vecs[i].valid ? mem_word(vecs[i].ipc) : 32'h0);
      tick();
    end

    // Stall fills the two-entry buffer, then fetch holds at 8.
    do_reset(0);
    stall = 1; auto_ack = 1;
    prep(); tick();
    prep(); tick();
    prep();
    check("st_addr4", imem_addr, 32'h4);
    check("st_head0", instr_pc, 32'h0);
    tick();
    prep();
    check("st_req_off", 32'(imem_req), 0);
    check("st_pc_hold", pc_next, 32'h8);
    tick();
    auto_ack = 0; imem_ack = 1;
    prep();
    check("st_ack_ignored", pc_next, 32'h8);
    check("st_still_idle", 32'(imem_req), 0);
    tick();
    imem_ack = 0; stall = 0;
    prep();
    check("st_head_valid", 32'(instr_valid), 1);
    check("st_head_pc", instr_pc, 32'h0);
    tick();
    auto_ack = 1;
    prep();
    check("st_refetch_req", 32'(imem_req), 1);
    check("st_refetch_addr", imem_addr, 32'h8);
    check("st_head_pc4", instr_pc, 32'h4);
    check("st_pc_next_c", pc_next, 32'hC);
    tick();

    // Redirect while request to 0x8 is outstanding without ack.
    do_reset(0);
    auto_ack = 1;
    prep(); tick();
    prep(); tick();
    prep(); tick();
    auto_ack = 0; imem_ack = 0;
    redirect = 1; redirect_pc = 32'h100;
    prep();
    check("rd_addr8", imem_addr, 32'h8);
    check("rd_pc_next", pc_next, 32'h100);
    tick();
    prep();
    check("rd_drop_req", 32'(imem_req), 1);
    check("rd_drop_addr", imem_addr, 32'h8);
    check("rd_flushed", 32'(instr_valid), 0);
    tick();
    imem_ack = 1;
    prep();
    check("rd_drop_pc_next", pc_next, 32'h100);
    tick();
    imem_ack = 0;
    prep();
    check("rd_idle_req", 32'(imem_req), 0);
    check("rd_discarded", 32'(instr_valid), 0);
    tick();
    auto_ack = 1;
    prep();
    check("rd_new_addr", imem_addr, 32'h100);
    tick();
    prep();
    check("rd_first_valid", 32'(instr_valid), 1);
    check("rd_first_pc", instr_pc, 32'h100);
    tick();

    // Redirect coincident with the ack for 0x4, then a misaligned redirect.
    do_reset(0);
    auto_ack = 1;
    prep(); tick();
    prep(); tick();
    auto_ack = 0; imem_ack = 1; redirect = 1; redirect_pc = 32'h200;
    prep();
    check("ra_addr4", imem_addr, 32'h4);
    check("ra_pc_next", pc_next, 32'h200);
    tick();
    imem_ack = 0;
    prep();
    check("ra_not_pushed", 32'(instr_valid), 0);
    check("ra_idle", 32'(imem_req), 0);
    tick();
    prep();
    check("ra_new_addr", imem_addr, 32'h200);
    redirect = 1; redirect_pc = 32'h103;
    #1;
    check("mis_pc_aligned", pc_next, 32'h100);
    check("mis_before", 32'(misalign_err), 0);
    tick();
    prep();
    check("mis_pulse", 32'(misalign_err), 1);
    check("mis_drop_addr", imem_addr, 32'h200);
    tick();
    imem_ack = 1;
    prep();
    check("mis_one_cycle", 32'(misalign_err), 0);
    tick();
    imem_ack = 0;

    // Reset asserted mid-request.
    do_reset(0);
    auto_ack = 1;
    prep(); tick();
    prep(); tick();
    prep(); tick();
    auto_ack = 0; imem_ack = 0;
    prep();
    check("mr_pre_req", 32'(imem_req), 1);
    rst = 1;
    #1;
    check("mr_req_drop", 32'(imem_req), 0);
    check("mr_valid", 32'(instr_valid), 0);
    check("mr_addr", imem_addr, 0);
    tick(); tick();
    rst = 0; auto_ack = 1;
    prep(); tick();
    prep();
    check("mr_restart_req", 32'(imem_req), 1);
    check("mr_restart_addr", imem_addr, 32'h0);
    tick();
    auto_ack = 0; imem_ack = 0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
